// File: rtl/fpu_pkg.sv
// Shared constants for the FPU load path: format codes, tag encodings and
// the exponent biases used to rebias memory formats into extended precision.
package fpu_pkg;

    localparam logic [2:0] FMT_SINGLE   = 3'd0;
    localparam logic [2:0] FMT_DOUBLE   = 3'd1;
    localparam logic [2:0] FMT_EXTENDED = 3'd2;
    localparam logic [2:0] FMT_INT16    = 3'd3;
    localparam logic [2:0] FMT_INT32    = 3'd4;
    localparam logic [2:0] FMT_INT64    = 3'd5;
    localparam logic [2:0] FMT_BCD      = 3'd6;
    localparam logic [2:0] FMT_RESERVED = 3'd7;

    localparam logic [1:0] TAG_VALID   = 2'b00;
    localparam logic [1:0] TAG_ZERO    = 2'b01;
    localparam logic [1:0] TAG_SPECIAL = 2'b10;
    localparam logic [1:0] TAG_EMPTY   = 2'b11;

    localparam logic [14:0] EXT_BIAS        = 15'd16383;
    localparam logic [14:0] EXT_EXP_MAX     = 15'h7FFF;
    localparam logic [14:0] SGL_BIAS_DELTA  = 15'd16256;
    localparam logic [14:0] DBL_BIAS_DELTA  = 15'd15360;
    localparam logic [14:0] INT_EXP         = 15'd16446;

    localparam logic [79:0] FPU_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;

endpackage

// File: rtl/fpu_bcd_accumulator.sv
// One step of packed-BCD to binary conversion: acc*10 + digit, flagging
// any nibble that is not a decimal digit.
module fpu_bcd_accumulator (
    input  logic [63:0] acc,
    input  logic [3:0]  digit,
    output logic [63:0] acc_next,
    output logic        digit_ok
);

    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {60'd0, digit};
        digit_ok = (digit <= 4'd9);
    end

endmodule

// File: rtl/fpu_format_loader.sv
// Converts a memory operand into an 80-bit extended value plus tag for the
// register stack. Packed-BCD loading is built only when FPU_BCD_LOAD_EN is defined.
module fpu_format_loader
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_format,
    input  logic [79:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] out_value,
    output logic [1:0]  out_tag,
    output logic        out_invalid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BCD  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state;
    logic        sign_q;
    logic [14:0] exp_q;
    logic [63:0] mant_q;
    logic [1:0]  tag_q;
    logic        invalid_q;

    logic        dec_sign;
    logic [14:0] dec_exp;
    logic [63:0] dec_mant;
    logic [1:0]  dec_tag;
    logic        dec_invalid;
    logic [1:0]  dec_state;
    logic        is_int;
    logic [63:0] int_val;
    logic [63:0] int_mag;

`ifdef FPU_BCD_LOAD_EN
    logic [71:0] bcd_digits;
    logic [4:0]  bcd_count;
    logic [63:0] acc_next;
    logic        digit_ok;

    fpu_bcd_accumulator u_bcd_acc (
        .acc      (mant_q),
        .digit    (bcd_digits[71:68]),
        .acc_next (acc_next),
        .digit_ok (digit_ok)
    );
`endif

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign out_value   = {sign_q, exp_q, mant_q};
    assign out_tag     = tag_q;
    assign out_invalid = invalid_q;

    // Operand decode happens in the accept cycle; only denormals and integers
    // whose magnitude lacks bit 63 need the serial normalizer.
    always_comb begin
        dec_sign    = 1'b0;
        dec_exp     = 15'd0;
        dec_mant    = 64'd0;
        dec_tag     = TAG_VALID;
        dec_invalid = 1'b0;
        dec_state   = ST_DONE;
        is_int      = 1'b0;
        int_val     = 64'd0;
        int_mag     = 64'd0;
        case (in_format)
            FMT_SINGLE: begin
                dec_sign = in_data[31];
                if (in_data[30:23] == 8'd0) begin
                    if (in_data[22:0] == 23'd0) begin
                        dec_tag = TAG_ZERO;
                    end else begin
                        dec_exp   = SGL_BIAS_DELTA + 15'd1;
                        dec_mant  = {1'b0, in_data[22:0], 40'd0};
                        dec_state = ST_NORM;
                    end
                end else if (in_data[30:23] == 8'hFF) begin
                    dec_exp  = EXT_EXP_MAX;
                    dec_mant = {1'b1, in_data[22:0], 40'd0};
                    dec_tag  = TAG_SPECIAL;
                end else begin
                    dec_exp  = {7'd0, in_data[30:23]} + SGL_BIAS_DELTA;
                    dec_mant = {1'b1, in_data[22:0], 40'd0};
                end
            end
            FMT_DOUBLE: begin
                dec_sign = in_data[63];
                if (in_data[62:52] == 11'd0) begin
                    if (in_data[51:0] == 52'd0) begin
                        dec_tag = TAG_ZERO;
                    end else begin
                        dec_exp   = DBL_BIAS_DELTA + 15'd1;
                        dec_mant  = {1'b0, in_data[51:0], 11'd0};
                        dec_state = ST_NORM;
                    end
                end else if (in_data[62:52] == 11'h7FF) begin
                    dec_exp  = EXT_EXP_MAX;
                    dec_mant = {1'b1, in_data[51:0], 11'd0};
                    dec_tag  = TAG_SPECIAL;
                end else begin
                    dec_exp  = {4'd0, in_data[62:52]} + DBL_BIAS_DELTA;
                    dec_mant = {1'b1, in_data[51:0], 11'd0};
                end
            end
            FMT_EXTENDED: begin
                dec_sign = in_data[79];
                dec_exp  = in_data[78:64];
                dec_mant = in_data[63:0];
                if (in_data[78:64] == 15'd0 && in_data[63:0] == 64'd0)
                    dec_tag = TAG_ZERO;
                else if (in_data[78:64] == EXT_EXP_MAX || in_data[78:64] == 15'd0)
                    dec_tag = TAG_SPECIAL;
            end
            FMT_INT16: begin
                is_int  = 1'b1;
                int_val = {{48{in_data[15]}}, in_data[15:0]};
            end
            FMT_INT32: begin
                is_int  = 1'b1;
                int_val = {{32{in_data[31]}}, in_data[31:0]};
            end
            FMT_INT64: begin
                is_int  = 1'b1;
                int_val = in_data[63:0];
            end
`ifdef FPU_BCD_LOAD_EN
            FMT_BCD: begin
                dec_sign  = in_data[79];
                dec_exp   = INT_EXP;
                dec_state = ST_BCD;
            end
`endif
            default: begin
                {dec_sign, dec_exp, dec_mant} = FPU_INDEFINITE;
                dec_tag     = TAG_SPECIAL;
                dec_invalid = 1'b1;
            end
        endcase
        if (is_int) begin
            int_mag = int_val[63] ? (~int_val + 64'd1) : int_val;
            if (int_mag == 64'd0) begin
                dec_tag = TAG_ZERO;
            end else begin
                dec_sign  = int_val[63];
                dec_exp   = INT_EXP;
                dec_mant  = int_mag;
                dec_state = int_mag[63] ? ST_DONE : ST_NORM;
            end
        end
    end

    // Sequencer: NORM finishes on the very shift that sets bit 63, giving a
    // latency of one accept cycle plus one cycle per leading zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= 15'd0;
            mant_q    <= 64'd0;
            tag_q     <= TAG_EMPTY;
            invalid_q <= 1'b0;
`ifdef FPU_BCD_LOAD_EN
            bcd_digits <= 72'd0;
            bcd_count  <= 5'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q    <= dec_sign;
                        exp_q     <= dec_exp;
                        mant_q    <= dec_mant;
                        tag_q     <= dec_tag;
                        invalid_q <= dec_invalid;
                        state     <= dec_state;
`ifdef FPU_BCD_LOAD_EN
                        bcd_digits <= in_data[71:0];
                        bcd_count  <= 5'd0;
`endif
                    end
                end
`ifdef FPU_BCD_LOAD_EN
                ST_BCD: begin
                    if (!digit_ok) begin
                        {sign_q, exp_q, mant_q} <= FPU_INDEFINITE;
                        tag_q     <= TAG_SPECIAL;
                        invalid_q <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        mant_q     <= acc_next;
                        bcd_digits <= bcd_digits << 4;
                        bcd_count  <= bcd_count + 5'd1;
                        if (bcd_count == 5'd17) begin
                            if (acc_next == 64'd0) begin
                                exp_q <= 15'd0;
                                tag_q <= TAG_ZERO;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_NORM;
                            end
                        end
                    end
                end
`endif
                ST_NORM: begin
                    if (mant_q[63]) begin
                        state <= ST_DONE;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 15'd1;
                        if (mant_q[62])
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_format_loader.sv
// Directed self-checking bench for fpu_format_loader; BCD vectors follow
// FPU_BCD_LOAD_EN so the same file covers both builds.
module tb_fpu_format_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_format = 3'd0;
    logic [79:0] in_data = 80'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [79:0] out_value;
    logic [1:0]  out_tag;
    logic        out_invalid;

    int check_count = 0;
    int error_count = 0;

    localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

    fpu_format_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_format   (in_format),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_tag     (out_tag),
        .out_invalid (out_invalid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents one operand and returns the number of clock edges from
    // acceptance until out_valid is seen (capped at 200).
    task automatic applyStimulus(input logic [2:0] fmt, input logic [79:0] data, output int latency);
        int wait_cycles;
        wait_cycles = 0;
        @(negedge clk);
        while (!in_ready && wait_cycles < 200) begin
            @(negedge clk);
            wait_cycles++;
        end
        in_format = fmt;
        in_data   = data;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic popResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runVector(input string name, input logic [2:0] fmt, input logic [79:0] data,
                             input logic [79:0] exp_value, input logic [1:0] exp_tag,
                             input logic exp_inv, input int exp_lat);
        int lat;
        applyStimulus(fmt, data, lat);
        checkOutput({name, " value"}, out_value, exp_value);
        checkOutput({name, " tag"}, {78'd0, out_tag}, {78'd0, exp_tag});
        checkOutput({name, " invalid"}, {79'd0, out_invalid}, {79'd0, exp_inv});
        if (exp_lat > 0)
            checkOutput({name, " latency"}, 80'(lat), 80'(exp_lat));
        popResult();
    endtask

    initial begin
        int lat;
        int cycles;

        #12;
        checkOutput("reset out_valid", {79'd0, out_valid}, 80'd0);
        checkOutput("reset out_tag", {78'd0, out_tag}, 80'd3);
        checkOutput("reset out_value", out_value, 80'd0);
        checkOutput("reset out_invalid", {79'd0, out_invalid}, 80'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset in_ready", {79'd0, in_ready}, 80'd1);

        runVector("single 1.0", 3'd0, 80'h3F80_0000, 80'h3FFF_8000_0000_0000_0000, 2'b00, 1'b0, 1);
        runVector("single denorm", 3'd0, 80'h0000_0001, 80'h3F6A_8000_0000_0000_0000, 2'b00, 1'b0, 24);
        runVector("single inf", 3'd0, 80'h7F80_0000, 80'h7FFF_8000_0000_0000_0000, 2'b10, 1'b0, 1);
        runVector("double 1.0", 3'd1, 80'h3FF0_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000, 2'b00, 1'b0, 1);
        runVector("double -0", 3'd1, 80'h8000_0000_0000_0000, 80'h8000_0000_0000_0000_0000, 2'b01, 1'b0, 1);
        runVector("double denorm", 3'd1, 80'h0000_0000_0000_0001, 80'h3BCD_8000_0000_0000_0000, 2'b00, 1'b0, 53);
        runVector("ext pi", 3'd2, 80'h4000_C90F_DAA2_2168_C235, 80'h4000_C90F_DAA2_2168_C235, 2'b00, 1'b0, 1);
        runVector("ext nan", 3'd2, 80'h7FFF_C000_0000_0000_0001, 80'h7FFF_C000_0000_0000_0001, 2'b10, 1'b0, 1);
        runVector("int16 -1", 3'd3, 80'hFFFF, 80'hBFFF_8000_0000_0000_0000, 2'b00, 1'b0, 64);
        runVector("int16 zero", 3'd3, 80'h0, 80'h0, 2'b01, 1'b0, 1);
        runVector("int32 5", 3'd4, 80'h5, 80'h4001_A000_0000_0000_0000, 2'b00, 1'b0, 62);
        runVector("int64 min", 3'd5, 80'h8000_0000_0000_0000, 80'hC03E_8000_0000_0000_0000, 2'b00, 1'b0, 1);
        runVector("reserved fmt", 3'd7, 80'h1234, INDEF, 2'b10, 1'b1, 1);
`ifdef FPU_BCD_LOAD_EN
        runVector("bcd +123", 3'd6, 80'h123, 80'h4005_F600_0000_0000_0000, 2'b00, 1'b0, 76);
        runVector("bcd bad digit", 3'd6, 80'hA, INDEF, 2'b10, 1'b1, 0);
`else
        runVector("bcd disabled", 3'd6, 80'h123, INDEF, 2'b10, 1'b1, 1);
`endif

        // Output stays frozen while the stack stalls.
        applyStimulus(3'd0, 80'hC000_0000, lat);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stall value", out_value, 80'hC000_8000_0000_0000_0000);
        checkOutput("stall tag", {78'd0, out_tag}, 80'd0);
        checkOutput("stall in_ready", {79'd0, in_ready}, 80'd0);
        checkOutput("stall out_valid", {79'd0, out_valid}, 80'd1);
        popResult();
        checkOutput("post handshake in_ready", {79'd0, in_ready}, 80'd1);

        // Async reset in the middle of normalization.
        @(negedge clk);
        in_format = 3'd3;
        in_data   = 80'h1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles = 0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midnorm out_valid", {79'd0, out_valid}, 80'd0);
        checkOutput("midnorm out_tag", {78'd0, out_tag}, 80'd3);
        checkOutput("midnorm out_value", out_value, 80'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after reset in_ready", {79'd0, in_ready}, 80'd1);
        runVector("post reset single", 3'd0, 80'h3F80_0000, 80'h3FFF_8000_0000_0000_0000, 2'b00, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
